// File: rtl/accu_seq_pkg.sv
// Shared definitions for the nibble-processor micro-sequencer: opcodes, ALU
// select codes, FSM state encoding and the decoded-control bundle.
package accu_seq_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LIT   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_CMPI  = 4'h3;
    localparam logic [3:0] OP_NANDI = 4'h4;
    localparam logic [3:0] OP_OUT   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JC    = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hA;

    localparam logic [2:0] SEL_PASS_A = 3'b000;
    localparam logic [2:0] SEL_PASS_B = 3'b010;
    localparam logic [2:0] SEL_NAND   = 3'b100;
    localparam logic [2:0] SEL_CMP    = 3'b001;
    localparam logic [2:0] SEL_ADD    = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_FETCH2 = 3'd3,
        ST_TARGET = 3'd4,
        ST_EXEC   = 3'd5,
        ST_HALTED = 3'd6
    } state_e;

    typedef struct packed {
        logic [2:0] alu_sel;
        logic       en_oprnd;
        logic       en_accu;
        logic       en_out;
        logic       sets_flags;
        logic       is_jump;
        logic       is_halt;
        logic       is_illegal;
    } dec_t;

    // Conditional-jump resolution against the registered flags.
    function automatic logic jump_taken(input logic [3:0] op, input logic c, input logic z);
        logic t;
        case (op)
            OP_JMP:  t = 1'b1;
            OP_JC:   t = c;
            OP_JZ:   t = z;
            OP_JNZ:  t = ~z;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/accu_seq_decode.sv
// Combinational opcode decoder: maps an opcode nibble to ALU select, datapath
// strobes and control-flow class.
module accu_seq_decode
    import accu_seq_pkg::*;
(
    input  logic [3:0] opcode_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '0;
        case (opcode_i)
            OP_NOP: dec_o = '0;
            OP_LIT: begin
                dec_o.alu_sel    = SEL_PASS_B;
                dec_o.en_oprnd   = 1'b1;
                dec_o.en_accu    = 1'b1;
                dec_o.sets_flags = 1'b1;
            end
            OP_ADDI: begin
                dec_o.alu_sel    = SEL_ADD;
                dec_o.en_oprnd   = 1'b1;
                dec_o.en_accu    = 1'b1;
                dec_o.sets_flags = 1'b1;
            end
            // Compare only updates flags; the accumulator keeps its value.
            OP_CMPI: begin
                dec_o.alu_sel    = SEL_CMP;
                dec_o.en_oprnd   = 1'b1;
                dec_o.sets_flags = 1'b1;
            end
            OP_NANDI: begin
                dec_o.alu_sel    = SEL_NAND;
                dec_o.en_oprnd   = 1'b1;
                dec_o.en_accu    = 1'b1;
                dec_o.sets_flags = 1'b1;
            end
            OP_OUT: begin
                dec_o.alu_sel = SEL_PASS_A;
                dec_o.en_out  = 1'b1;
            end
            OP_JMP, OP_JC, OP_JZ, OP_JNZ: dec_o.is_jump = 1'b1;
            OP_HALT: dec_o.is_halt = 1'b1;
            default: dec_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/accu_seq_ctrl.sv
// Top-level micro-sequencer: fetch/decode/execute FSM, pc, ir and flags.
// Optional macro ACCU_SEQ_ILLEGAL_TRAP_EN adds the illegal output and traps opcodes B-F.
module accu_seq_ctrl
    import accu_seq_pkg::*;
#(
    parameter int PC_W = 8
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic [PC_W-1:0] prog_addr,
    input  logic [7:0]      prog_data,
    output logic [3:0]      oprnd,
    output logic            en_oprnd,
    output logic            en_accu,
    output logic            en_out,
    output logic [2:0]      alu_sel,
    input  logic            alu_carry,
    input  logic            alu_zero,
    input  logic            out_ready,
    output logic            carry_flag,
    output logic            zero_flag,
`ifdef ACCU_SEQ_ILLEGAL_TRAP_EN
    output logic            illegal,
`endif
    output logic            halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;
`ifdef ACCU_SEQ_ILLEGAL_TRAP_EN
    logic            illegal_q, illegal_d;
`endif

    logic [3:0] dec_op;
    dec_t       dec;

    // In DECODE the fresh ROM byte is classified; elsewhere the latched ir drives control.
    assign dec_op = (state_q == ST_DECODE) ? prog_data[7:4] : ir_q[7:4];

    accu_seq_decode u_decode (
        .opcode_i (dec_op),
        .dec_o    (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= 8'h00;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
`ifdef ACCU_SEQ_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
`ifdef ACCU_SEQ_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
`ifdef ACCU_SEQ_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
                else     state_d = ST_IDLE;
            end
            ST_FETCH: begin
                if (run) state_d = ST_DECODE;
                else     state_d = ST_IDLE;
            end
            ST_DECODE: begin
                ir_d = prog_data;
                pc_d = pc_q + PC_W'(1);
                if (dec.is_jump)      state_d = ST_FETCH2;
                else if (dec.is_halt) state_d = ST_HALTED;
`ifdef ACCU_SEQ_ILLEGAL_TRAP_EN
                else if (dec.is_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALTED;
                end
`else
                else if (dec.is_illegal) state_d = ST_EXEC;
`endif
                else                  state_d = ST_EXEC;
            end
            ST_FETCH2: state_d = ST_TARGET;
            // prog_data now holds the target byte fetched from the incremented pc.
            ST_TARGET: begin
                if (jump_taken(ir_q[7:4], carry_q, zero_q)) pc_d = prog_data[PC_W-1:0];
                else                                        pc_d = pc_q + PC_W'(1);
                state_d = ST_FETCH;
            end
            ST_EXEC: begin
                if (dec.sets_flags) begin
                    carry_d = alu_carry;
                    zero_d  = alu_zero;
                end else begin
                    carry_d = carry_q;
                    zero_d  = zero_q;
                end
                if (dec.en_out && !out_ready) state_d = ST_EXEC;
                else                          state_d = ST_FETCH;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_sel  = SEL_PASS_A;
        en_oprnd = 1'b0;
        en_accu  = 1'b0;
        en_out   = 1'b0;
        oprnd    = 4'h0;
        if (state_q == ST_EXEC) begin
            alu_sel  = dec.alu_sel;
            en_oprnd = dec.en_oprnd;
            en_accu  = dec.en_accu;
            en_out   = dec.en_out;
            oprnd    = ir_q[3:0];
        end else begin
            alu_sel  = SEL_PASS_A;
            en_oprnd = 1'b0;
            en_accu  = 1'b0;
            en_out   = 1'b0;
            oprnd    = 4'h0;
        end
    end

    assign prog_addr  = pc_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
    assign halted     = (state_q == ST_HALTED);
`ifdef ACCU_SEQ_ILLEGAL_TRAP_EN
    assign illegal    = illegal_q;
`endif

endmodule

// File: tb/tb_accu_seq_ctrl.sv
// Directed bench for accu_seq_ctrl with a synchronous ROM and a 4-bit
// accumulator/ALU datapath model attached.
module tb_accu_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset, run, out_ready;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] oprnd;
    logic       en_oprnd, en_accu, en_out;
    logic [2:0] alu_sel;
    logic       alu_carry, alu_zero;
    logic       carry_flag, zero_flag, halted;
`ifdef ACCU_SEQ_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    logic [7:0] rom [256];
    logic [3:0] acc, alu_b, alu_res;
    logic [3:0] dp_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    accu_seq_ctrl #(.PC_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .oprnd      (oprnd),
        .en_oprnd   (en_oprnd),
        .en_accu    (en_accu),
        .en_out     (en_out),
        .alu_sel    (alu_sel),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .out_ready  (out_ready),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
`ifdef ACCU_SEQ_ILLEGAL_TRAP_EN
        .illegal    (illegal),
`endif
        .halted     (halted)
    );

    always @(posedge clk) prog_data <= rom[prog_addr];

    // Datapath model: operand buffer, ALU, accumulator, output buffer.
    always_comb begin
        alu_b     = en_oprnd ? oprnd : 4'h0;
        alu_res   = acc;
        alu_carry = 1'b0;
        case (alu_sel)
            3'b010:  alu_res = alu_b;
            3'b011:  {alu_carry, alu_res} = {1'b0, acc} + {1'b0, alu_b};
            3'b001:  begin
                alu_res   = acc - alu_b;
                alu_carry = (acc < alu_b);
            end
            3'b100:  alu_res = ~(acc & alu_b);
            default: alu_res = acc;
        endcase
        alu_zero = (alu_res == 4'h0);
        dp_out   = en_out ? acc : 4'h0;
    end

    always @(posedge clk) begin
        if (reset)        acc <= 4'h0;
        else if (en_accu) acc <= alu_res;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'hA0;
    endtask

    // Two reset cycles, then release with run high; DUT sits in IDLE.
    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        out_ready = 1'b1;
        tick(2);
        reset = 1'b0;
        run = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
        out_ready = 1'b1;

        // ---- Program 1: LIT 5, ADDI 3, OUT, HALT
        fill_rom();
        rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h50; rom[3] = 8'hA0;
        do_reset();
        check("rst_addr", prog_addr, 8'h00);
        check("rst_en", {en_oprnd, en_accu, en_out}, 3'b000);
        check("rst_sel", alu_sel, 3'b000);
        check("rst_halt", halted, 1'b0);
        check("rst_flags", {carry_flag, zero_flag}, 2'b00);
        tick(3);
        check("lit_sel", alu_sel, 3'b010);
        check("lit_en", {en_oprnd, en_accu, en_out}, 3'b110);
        check("lit_oprnd", oprnd, 4'h5);
        tick(3);
        check("addi_sel", alu_sel, 3'b011);
        tick(1);
        check("p1_fetch2_addr", prog_addr, 8'h02);
        check("p1_acc", acc, 4'h8);
        tick(2);
        check("out_en", {en_oprnd, en_accu, en_out}, 3'b001);
        check("out_sel", alu_sel, 3'b000);
        check("out_data", dp_out, 4'h8);
        tick(1);
        check("p1_fetch3_addr", prog_addr, 8'h03);
        check("p1_not_halted", halted, 1'b0);
        tick(2);
        check("p1_halted", halted, 1'b1);
        check("p1_flags", {carry_flag, zero_flag}, 2'b00);
        check("p1_halt_addr", prog_addr, 8'h04);
        tick(3);
        check("p1_stays_halted", halted, 1'b1);

        // ---- Program 2: LIT F, ADDI 1, JC 0x10 (taken)
        fill_rom();
        rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h70; rom[3] = 8'h10;
        do_reset();
        check("p2_rst_halt", halted, 1'b0);
        tick(6);
        check("p2_addi_sel", alu_sel, 3'b011);
        tick(1);
        check("p2_flags", {carry_flag, zero_flag}, 2'b11);
        check("p2_acc", acc, 4'h0);
        tick(2);
        check("p2_fetch2_addr", prog_addr, 8'h03);
        check("p2_jump_no_en", {en_oprnd, en_accu, en_out}, 3'b000);
        tick(2);
        check("p2_target_addr", prog_addr, 8'h10);
        check("p2_jump_flags", {carry_flag, zero_flag}, 2'b11);
        tick(2);
        check("p2_halted", halted, 1'b1);

        // ---- Program 3: LIT 7, CMPI 7, JNZ 0x20 (not taken)
        fill_rom();
        rom[0] = 8'h17; rom[1] = 8'h37; rom[2] = 8'h90; rom[3] = 8'h20; rom[4] = 8'h15;
        do_reset();
        tick(6);
        check("cmpi_sel", alu_sel, 3'b001);
        check("cmpi_en", {en_oprnd, en_accu, en_out}, 3'b100);
        tick(1);
        check("p3_flags", {carry_flag, zero_flag}, 2'b01);
        tick(4);
        check("p3_fallthru_addr", prog_addr, 8'h04);
        check("p3_acc", acc, 4'h7);
        tick(2);
        check("p3_lit_oprnd", oprnd, 4'h5);

        // ---- Program 4: OUT stalled five cycles on out_ready
        fill_rom();
        rom[0] = 8'h50; rom[1] = 8'hA0;
        do_reset();
        out_ready = 1'b0;
        tick(3);
        for (int i = 0; i < 6; i++) begin
            out_ready = (i == 5);
            check("stall_en_out", en_out, 1'b1);
            check("stall_addr", prog_addr, 8'h01);
            check("stall_flags", {carry_flag, zero_flag}, 2'b00);
            tick(1);
        end
        check("stall_done_en", en_out, 1'b0);
        check("stall_done_addr", prog_addr, 8'h01);
        check("stall_done_halt", halted, 1'b0);

        // ---- Program 5: run low in EXEC, resume, reset during OUT stall
        fill_rom();
        rom[0] = 8'h11; rom[1] = 8'h50;
        do_reset();
        tick(3);
        check("p5_lit_en", en_accu, 1'b1);
        run = 1'b0;
        tick(1);
        check("p5_fetch_addr", prog_addr, 8'h01);
        tick(3);
        check("p5_idle_addr", prog_addr, 8'h01);
        check("p5_idle_en", {en_oprnd, en_accu, en_out}, 3'b000);
        run = 1'b1;
        out_ready = 1'b0;
        tick(3);
        check("p5_out_en", en_out, 1'b1);
        check("p5_out_data", dp_out, 4'h1);
        tick(1);
        check("p5_stall_en", en_out, 1'b1);
        reset = 1'b1;
        tick(1);
        check("p5_rst_en", {en_oprnd, en_accu, en_out}, 3'b000);
        check("p5_rst_addr", prog_addr, 8'h00);
        check("p5_rst_sel", alu_sel, 3'b000);
        check("p5_rst_halt", halted, 1'b0);
        reset = 1'b0;
        run = 1'b0;
        tick(2);
        check("p5_idle_after_rst", prog_addr, 8'h00);
        check("p5_idle_after_rst_en", en_out, 1'b0);

        // ---- Program 6: illegal opcode F0 at pc=3
        fill_rom();
        rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'hF0; rom[4] = 8'h11;
        do_reset();
        tick(3);
        check("nop_en", {en_oprnd, en_accu, en_out}, 3'b000);
        tick(7);
        check("ill_fetch_addr", prog_addr, 8'h03);
        tick(2);
        check("ill_addr", prog_addr, 8'h04);
        check("ill_en", {en_oprnd, en_accu, en_out}, 3'b000);
        check("ill_sel", alu_sel, 3'b000);
`ifdef ACCU_SEQ_ILLEGAL_TRAP_EN
        check("ill_flag", illegal, 1'b1);
        check("ill_halted", halted, 1'b1);
`else
        check("ill_nop_halt", halted, 1'b0);
        tick(1);
        check("ill_next_addr", prog_addr, 8'h04);
        tick(2);
        check("ill_next_lit", en_accu, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
